chan_sel_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 7:1 output mux and drives its 3-bit select.
- Seven sources raise request lines. The block grants one source at a time and presents its index as the mux select, with a valid flag.
- The grant is held until one of three things happens: the downstream consumer acknowledges, the source drops its request, or a hold timeout expires.
- The select value 3'b111 is never produced.

---
 rtl/chan_sel_arbiter.sv | 138 +++++++++++++
 tb/tb_chan_sel_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_sel_arbiter.sv
// rtl/chan_sel_arbiter.sv - round-robin arbiter driving the 7:1 output mux select
//
// Purpose: grants one of seven requesters at a time and presents its index as
// the mux select. A grant is held until acknowledge, request drop or hold timeout.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   req  in   [6:0] request lines, req[k] = source k
//   a    in   downstream acknowledge, releases the current grant
//   s    out  [2:0] mux select (0..6), meaningful while v=1
//   v    out  grant valid
//   g    out  [6:0] one-hot grant, g[s]=1 while v=1
//   to   out  one-cycle pulse after a timeout-only release

module chan_sel_arbiter #(
  parameter int MAX_CYC = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] req,
  input  logic       a,
  output logic [2:0] s,
  output logic       v,
  output logic [6:0] g,
  output logic       to
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYC - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    last, last_nxt;
  logic [2:0]    s_nxt;
  logic          v_nxt;
  logic [6:0]    g_nxt;
  logic          to_nxt;

  // Padded copy so a 3-bit index never selects outside the vector.
  logic [7:0]    req_x;
  logic [2:0]    base;
  logic [2:0]    win;
  logic [3:0]    idx;
  logic          found;
  logic          any_req;
  logic          at_max;
  logic          rel;

  assign req_x   = {1'b0, req};
  assign any_req = |req;
  assign at_max  = (cnt == CNT_MAX);
  assign rel     = a | ~req_x[s] | at_max;
  assign base    = (state == GRANT) ? s : last;

  // Scan base+1 .. base+7 modulo 7; the final step revisits base itself so a
  // lone requester can be regranted. Index 7 is never reached.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      idx = {1'b0, base} + 4'(i);
      if (idx >= 4'd7) idx = idx - 4'd7;
      if (!found && req_x[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    s_nxt     = s;
    v_nxt     = v;
    g_nxt     = g;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (any_req) begin
          state_nxt = GRANT;
          s_nxt     = win;
          g_nxt     = 7'b1 << win;
          v_nxt     = 1'b1;
        end else begin
          v_nxt = 1'b0;
          g_nxt = 7'b0;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_nxt = cnt + CW'(1);
        end else begin
          last_nxt = s;
          cnt_nxt  = '0;
          // Pulse only when the counter alone forced the release.
          to_nxt   = at_max & ~a & req_x[s];
          if (any_req) begin
            s_nxt = win;
            g_nxt = 7'b1 << win;
            v_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            v_nxt     = 1'b0;
            g_nxt     = 7'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 3'd6;
      s     <= 3'd0;
      v     <= 1'b0;
      g     <= 7'b0;
      to    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      s     <= s_nxt;
      v     <= v_nxt;
      g     <= g_nxt;
      to    <= to_nxt;
    end
  end

endmodule

// File: tb/tb_chan_sel_arbiter.sv
// tb/tb_chan_sel_arbiter.sv - scoreboard bench for chan_sel_arbiter

module tb_chan_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [6:0] req;
  logic       a;
  logic [2:0] s;
  logic       v;
  logic [6:0] g;
  logic       to;

  logic [13:0] obs;
  assign obs = {s, v, g, to};

  logic [13:0] expq[$];
  int errors;
  int checks;

  chan_sel_arbiter #(.MAX_CYC(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .s(s), .v(v), .g(g), .to(to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] mk_idle(int sel);
    return {3'(sel), 1'b0, 7'b0, 1'b0};
  endfunction

  function automatic logic [13:0] mk_grant(int sel, logic t);
    logic [6:0] one;
    one = 7'b1 << sel;
    return {3'(sel), 1'b1, one, t};
  endfunction

  task automatic test_reset();
    logic [13:0] e;
    rst = 1'b1; req = 7'h7F; a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expq.push_back(mk_idle(0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", i, obs, e); end
    end
    rst = 1'b0;
    expq.push_back(mk_grant(0, 1'b0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_first_grant: got %h want %h", obs, e); end
  endtask

  task automatic test_round_robin();
    logic [13:0] e;
    req = 7'h7F; a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      expq.push_back(mk_grant(i % 7, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e || s === 3'b111) begin
        errors++; $display("FAIL round_robin[%0d]: got %h want %h", i, obs, e);
      end
    end
    a = 1'b0;
  endtask

  task automatic test_sparse_wrap();
    logic [13:0] e;
    int seq[4] = '{6, 0, 6, 0};
    req = 7'b1000001; a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expq.push_back(mk_grant(seq[i], 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sparse_wrap[%0d]: got %h want %h", i, obs, e); end
    end
    req = 7'b0000001;
    for (int i = 0; i < 3; i++) begin
      expq.push_back(mk_grant(0, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sole_regrant[%0d]: got %h want %h", i, obs, e); end
    end
    a = 1'b0;
  endtask

  task automatic test_req_drop();
    logic [13:0] e;
    req = 7'h00; a = 1'b0;
    expq.push_back(mk_idle(0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL drop_to_idle: got %h want %h", obs, e); end
    req = 7'h08;
    expq.push_back(mk_grant(3, 1'b0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL grant3: got %h want %h", obs, e); end
    // Other sources toggling must not disturb the grant.
    req = 7'h28;
    expq.push_back(mk_grant(3, 1'b0));
    tick();
    req = 7'h09;
    expq.push_back(mk_grant(3, 1'b0));
    tick();
    for (int i = 0; i < 1; i++) begin
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL other_req_hold: got %h want %h", obs, e); end
    end
    e = expq.pop_front();
    req = 7'h00;
    expq.push_back(mk_idle(3));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL drop3_idle: got %h want %h", obs, e); end
    a = 1'b1;
    expq.push_back(mk_idle(3));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ack_in_idle: got %h want %h", obs, e); end
    a = 1'b0; req = 7'h08;
    expq.push_back(mk_grant(3, 1'b0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL regrant3: got %h want %h", obs, e); end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    req = 7'h00;
    expq.push_back(mk_idle(3));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL to_pre_idle: got %h want %h", obs, e); end
    req = 7'h04;
    for (int i = 0; i < 16; i++) begin
      expq.push_back(mk_grant(2, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL to_hold[%0d]: got %h want %h", i, obs, e); end
    end
    expq.push_back(mk_grant(2, 1'b1));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL to_pulse_same: got %h want %h", obs, e); end
    req = 7'h06;
    for (int i = 0; i < 15; i++) begin
      expq.push_back(mk_grant(2, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL to_hold2[%0d]: got %h want %h", i, obs, e); end
    end
    expq.push_back(mk_grant(1, 1'b1));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL to_wrap_2to1: got %h want %h", obs, e); end
    for (int i = 0; i < 15; i++) begin
      expq.push_back(mk_grant(1, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL to_hold3[%0d]: got %h want %h", i, obs, e); end
    end
    // Acknowledge on the timeout cycle suppresses the pulse.
    a = 1'b1;
    expq.push_back(mk_grant(2, 1'b0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL to_with_ack: got %h want %h", obs, e); end
    a = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    logic [13:0] e;
    req = 7'h20;
    for (int i = 0; i < 8; i++) begin
      expq.push_back(mk_grant(5, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_hold5[%0d]: got %h want %h", i, obs, e); end
    end
    rst = 1'b1; req = 7'h7F;
    expq.push_back(mk_idle(0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_reset: got %h want %h", obs, e); end
    rst = 1'b0;
    expq.push_back(mk_grant(0, 1'b0));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_src0: got %h want %h", obs, e); end
    // cnt must have restarted: full 16-cycle hold before the next timeout.
    req = 7'h01;
    for (int i = 0; i < 15; i++) begin
      expq.push_back(mk_grant(0, 1'b0));
      tick();
      e = expq.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL post_reset_hold[%0d]: got %h want %h", i, obs, e); end
    end
    expq.push_back(mk_grant(0, 1'b1));
    tick();
    e = expq.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_reset_timeout: got %h want %h", obs, e); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; req = 7'h00; a = 1'b0;
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_req_drop();
    test_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
